// File: rtl/memtile_pkg.sv
// Shared types and delay-config helpers for the delay-line memory tile.
package memtile_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_DEPTH      = 512;
    localparam int DEF_DELAY      = 62;
    localparam int MIN_DELAY      = 2;

    typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

    typedef struct packed {
        logic                     valid;
        lane_t [DEF_NUM_CH-1:0]   data;
    } word_t;

    function automatic int unsigned clamp_delay(
        input int unsigned d,
        input int unsigned depth
    );
        if (d < MIN_DELAY) return MIN_DELAY;
        if (d > depth)     return depth;
        return d;
    endfunction

    function automatic logic delay_legal(
        input int unsigned d,
        input int unsigned depth
    );
        return (d >= MIN_DELAY) && (d <= depth);
    endfunction

endpackage

// File: rtl/memtile_delay_line_sram.sv
// Behavioural 1-write 1-read memory with a registered read port.
module delay_sram_1r1w #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 33,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/memtile_delay_line.sv
// Programmable multi-lane delay line: data_out(t) = data_in(t - delay_q).
module memtile_delay_line
    import memtile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int DEFAULT_DELAY = DEF_DELAY
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              clk_en,
    input  logic [ADDR_W:0]                   cfg_delay,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_in,
    input  logic                              valid_in,
    input  logic                              enable_chain_input,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] chain_data_in,
    input  logic                              chain_valid_in,
    input  logic                              enable_chain_output,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_out,
    output logic                              valid_out,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0] chain_data_out,
    output logic                              chain_valid_out,
    output logic                              cfg_err
);

    localparam int DW = ADDR_W + 1;
    localparam int WW = 1 + NUM_CH * DATA_WIDTH;

    typedef struct packed {
        logic                              valid;
        logic [NUM_CH-1:0][DATA_WIDTH-1:0] data;
    } tile_word_t;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] raddr;
    logic [DW-1:0]     fill;
    logic [DW-1:0]     fill_inc;
    logic [DW-1:0]     fill_nxt;
    logic [DW-1:0]     delay_q;
    logic              adv;
    logic              primed_q;
    logic              out_live;
    tile_word_t        src;
    tile_word_t        rd;
    logic [WW-1:0]     rd_bits;

    assign adv = clk_en & ~flush;

    always_comb begin
        src = '0;
        if (enable_chain_input) begin
            src.valid = chain_valid_in;
            src.data  = chain_data_in;
        end else begin
            src.valid = valid_in;
            src.data  = data_in;
        end
    end

    // Reading D-1 words behind the write pointer plus the 1-cycle read gives D.
    assign raddr    = wptr - delay_q[ADDR_W-1:0] + ADDR_W'(1);
    assign fill_inc = fill + DW'(1);
    assign fill_nxt = (fill_inc >= delay_q) ? delay_q : fill_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            fill     <= '0;
            delay_q  <= DW'(DEFAULT_DELAY);
            cfg_err  <= 1'b0;
            primed_q <= 1'b0;
            out_live <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            fill     <= '0;
            delay_q  <= DW'(clamp_delay(32'(cfg_delay), DEPTH));
            cfg_err  <= ~delay_legal(32'(cfg_delay), DEPTH);
            primed_q <= 1'b0;
            out_live <= 1'b0;
        end else if (clk_en) begin
            wptr     <= wptr + ADDR_W'(1);
            fill     <= fill_nxt;
            primed_q <= (fill_nxt == delay_q);
            out_live <= 1'b1;
        end
    end

    delay_sram_1r1w #(
        .DEPTH  (DEPTH),
        .WIDTH  (WW),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .we    (adv),
        .waddr (wptr),
        .wdata (src),
        .re    (adv),
        .raddr (raddr),
        .rdata (rd_bits)
    );

    assign rd = rd_bits;

    // The array has no reset, so its read register is masked until a real read.
    assign data_out        = out_live ? rd.data : '0;
    assign valid_out       = primed_q & rd.valid;
    assign chain_data_out  = data_out;
    assign chain_valid_out = valid_out & enable_chain_output;

endmodule

// File: tb/tb_memtile_delay_line.sv
// Scoreboard bench for memtile_delay_line: tile A feeds tile B through the chain ports.
module tb_memtile_delay_line;
    import memtile_pkg::*;

    localparam int DWT = 16;
    localparam int NCH = 2;
    localparam int AW  = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic clk_en = 1'b0;
    logic [AW:0] cfg_delay = '0;
    logic [NCH-1:0][DWT-1:0] data_in = '0;
    logic [NCH-1:0][DWT-1:0] zero_data = '0;
    logic valid_in = 1'b0;
    logic eco = 1'b1;
    logic tie0 = 1'b0;
    logic tie1 = 1'b1;

    logic [NCH-1:0][DWT-1:0] a_data_out, a_chain_data_out;
    logic a_valid_out, a_chain_valid_out, a_cfg_err;
    logic [NCH-1:0][DWT-1:0] b_data_out, b_chain_data_out;
    logic b_valid_out, b_chain_valid_out, b_cfg_err;

    always #5 clk = ~clk;

    memtile_delay_line u_a (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .clk_en              (clk_en),
        .cfg_delay           (cfg_delay),
        .data_in             (data_in),
        .valid_in            (valid_in),
        .enable_chain_input  (tie0),
        .chain_data_in       (zero_data),
        .chain_valid_in      (tie0),
        .enable_chain_output (eco),
        .data_out            (a_data_out),
        .valid_out           (a_valid_out),
        .chain_data_out      (a_chain_data_out),
        .chain_valid_out     (a_chain_valid_out),
        .cfg_err             (a_cfg_err)
    );

    memtile_delay_line u_b (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .clk_en              (clk_en),
        .cfg_delay           (cfg_delay),
        .data_in             (zero_data),
        .valid_in            (tie0),
        .enable_chain_input  (tie1),
        .chain_data_in       (a_chain_data_out),
        .chain_valid_in      (a_chain_valid_out),
        .enable_chain_output (tie0),
        .data_out            (b_data_out),
        .valid_out           (b_valid_out),
        .chain_data_out      (b_chain_data_out),
        .chain_valid_out     (b_chain_valid_out),
        .cfg_err             (b_cfg_err)
    );

    int n_checks = 0;
    int n_fail = 0;

    word_t qa[$];
    word_t qb[$];
    word_t ea = '0;
    word_t eb = '0;
    int da = 62;
    int db = 62;
    logic exp_err = 1'b0;
    logic zero_chk = 1'b1;
    int seq = 0;

    typedef struct {
        logic [AW:0] cfg;
        int          exp_d;
        logic        exp_err;
    } cfg_vec_t;

    cfg_vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int tb_clamp(input int c);
        if (c < 2) return 2;
        if (c > 512) return 512;
        return c;
    endfunction

    task automatic compare();
        chk("a_valid", a_valid_out, ea.valid);
        chk("a_chain_valid", a_chain_valid_out, ea.valid & eco);
        if (ea.valid) chk("a_data", a_data_out, ea.data);
        if (ea.valid) chk("a_chain_data", a_chain_data_out, ea.data);
        chk("b_valid", b_valid_out, eb.valid);
        if (eb.valid) chk("b_data", b_data_out, eb.data);
        if (zero_chk) begin
            chk("a_zero", a_data_out, 64'd0);
            chk("b_zero", b_data_out, 64'd0);
        end
        chk("a_cfg_err", a_cfg_err, exp_err);
        chk("b_cfg_err", b_cfg_err, exp_err);
    endtask

    // Inputs are already driven; sample the edge and advance the model.
    task automatic tick();
        word_t sa;
        word_t sb;
        @(posedge clk);
        #1;
        if (flush) begin
            qa.delete();
            qb.delete();
            da = tb_clamp(int'(cfg_delay));
            db = da;
            exp_err = (cfg_delay < 2) || (cfg_delay > 512);
            ea = '0;
            eb = '0;
            zero_chk = 1'b1;
        end else if (clk_en) begin
            sa.valid = valid_in;
            sa.data  = data_in;
            sb.valid = ea.valid & eco;
            sb.data  = ea.data;
            qa.push_back(sa);
            qb.push_back(sb);
            if (qa.size() == da) ea = qa.pop_front();
            else ea = '0;
            if (qb.size() == db) eb = qb.pop_front();
            else eb = '0;
            zero_chk = 1'b0;
        end
        compare();
    endtask

    task automatic drive_one(input logic v);
        flush = 1'b0;
        clk_en = 1'b1;
        valid_in = v;
        data_in[0] = 16'(seq);
        data_in[1] = 16'(seq * 7 + 16'h3c1);
        tick();
        seq++;
    endtask

    task automatic stall_one();
        flush = 1'b0;
        clk_en = 1'b0;
        valid_in = 1'b1;
        data_in[0] = 16'hdead;
        data_in[1] = 16'hbeef;
        tick();
    endtask

    task automatic do_flush(input int c);
        flush = 1'b1;
        clk_en = 1'b1;
        cfg_delay = (AW + 1)'(c);
        tick();
        flush = 1'b0;
        cfg_delay = '0;
    endtask

    initial begin
        int first;
        logic [4:0] pat;
        logic [DWT-1:0] l0;
        logic [DWT-1:0] l1;

        tbl[0] = '{cfg: 10'd1,   exp_d: 2,   exp_err: 1'b1};
        tbl[1] = '{cfg: 10'd600, exp_d: 512, exp_err: 1'b1};
        tbl[2] = '{cfg: 10'd8,   exp_d: 8,   exp_err: 1'b0};
        tbl[3] = '{cfg: 10'd513, exp_d: 512, exp_err: 1'b1};
        tbl[4] = '{cfg: 10'd2,   exp_d: 2,   exp_err: 1'b0};

        #2;
        chk("rst_valid", a_valid_out, 64'd0);
        chk("rst_data", a_data_out, 64'd0);
        chk("rst_chain_valid", a_chain_valid_out, 64'd0);
        chk("rst_cfg_err", a_cfg_err, 64'd0);
        #10;
        rst_n = 1'b1;

        // Ramp at the default delay of 62.
        do_flush(62);
        seq = 0;
        first = -1;
        for (int i = 0; i < 70; i++) begin
            drive_one(1'b1);
            if (a_valid_out && first < 0) begin
                first = i + 1;
                chk("t1_data0", a_data_out[0], 64'd0);
            end
        end
        chk("t1_first", first, 64'd62);

        // Full-depth delay across several pointer wraps.
        do_flush(512);
        for (int i = 0; i < 2000; i++) drive_one(1'b1);

        // Valid pattern, stall and gated chain output at D=10.
        do_flush(10);
        pat = 5'b01101;
        for (int i = 0; i < 30; i++) drive_one(pat[i % 5]);
        for (int i = 0; i < 5; i++) stall_one();
        eco = 1'b0;
        for (int i = 0; i < 12; i++) drive_one(pat[i % 5]);
        eco = 1'b1;
        for (int i = 0; i < 20; i++) drive_one(pat[i % 5]);

        // Config clamping table: latency in enabled cycles and cfg_err.
        for (int k = 0; k < 5; k++) begin
            do_flush(int'(tbl[k].cfg));
            chk("t4_cfg_err", a_cfg_err, tbl[k].exp_err);
            first = -1;
            for (int i = 0; i < tbl[k].exp_d + 4; i++) begin
                drive_one(1'b1);
                if (a_valid_out && first < 0) first = i + 1;
            end
            chk("t4_latency", first, tbl[k].exp_d);
        end

        // Cascade 300 + 300.
        do_flush(300);
        l0 = 16'(seq);
        l1 = 16'(seq * 7 + 16'h3c1);
        first = -1;
        for (int i = 0; i < 610; i++) begin
            drive_one(1'b1);
            if (b_valid_out && first < 0) begin
                first = i + 1;
                chk("t5_lane0", b_data_out[0], l0);
                chk("t5_lane1", b_data_out[1], l1);
            end
        end
        chk("t5_first", first, 64'd600);

        // Asynchronous reset mid-stream.
        do_flush(1);
        for (int i = 0; i < 10; i++) drive_one(1'b1);
        chk("t6_pre_valid", a_valid_out, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", a_valid_out, 64'd0);
        chk("t6_data", a_data_out, 64'd0);
        chk("t6_chain_valid", a_chain_valid_out, 64'd0);
        chk("t6_cfg_err", a_cfg_err, 64'd0);
        qa.delete();
        qb.delete();
        da = 62;
        db = 62;
        ea = '0;
        eb = '0;
        exp_err = 1'b0;
        zero_chk = 1'b1;
        #2;
        rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 70; i++) begin
            drive_one(1'b1);
            if (a_valid_out && first < 0) first = i + 1;
        end
        chk("t6_first", first, 64'd62);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
